// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, imem request/ack handshake, {word, addr} buffer, branch redirect.
// Latency: ack in cycle N -> ins_valid in N+1 (empty buffer); next request in N+1 at pc+4.
// Backpressure: no new request while the buffer is full; ins/ins_pc hold while ins_valid && !ins_ready.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_req/imem_addr             fetch request, held with a stable address until imem_ack
//   imem_ack/imem_rdata            memory response, ignored while imem_req is low
//   ins_valid/ins/opcode/ins_pc    buffer head presented to decode/control
//   ins_ready                      decode consumes the head when ins_valid && ins_ready
//   branch/branch_target           redirect: flush buffer, drop stale response, refetch at target
module instr_fetch #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              ins_valid,
  output logic [31:0]       ins,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]        buf_word_q [BUF_DEPTH];
  logic [ADDR_W-1:0]  buf_addr_q [BUF_DEPTH];

  logic ack_acc;
  logic outstanding;
  logic push;
  logic pop;
  logic hold_req;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins_valid = (count_q != '0);
  assign ins       = buf_word_q[rd_ptr_q];
  assign ins_pc    = buf_addr_q[rd_ptr_q];
  assign opcode    = ins[31:26];

  always_comb begin
    ack_acc     = req_q & imem_ack;
    outstanding = req_q & ~imem_ack;
    // A response landing in DRAIN, or together with a branch, belongs to the old stream.
    push        = (state_q == FETCH) & ack_acc & ~branch;
    // Branch flushes the whole buffer, so a simultaneous consume is irrelevant.
    pop         = ins_valid & ins_ready & ~branch;

    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    req_d   = 1'b0;
    addr_d  = addr_q;

    case (state_q)
      FETCH:   if (branch && outstanding) state_d = DRAIN;
      DRAIN:   if (ack_acc)               state_d = FETCH;
      default: state_d = FETCH;
    endcase

    if (branch)    pc_d = branch_target;
    else if (push) pc_d = pc_q + ADDR_W'(4);

    if (branch) count_d = '0;
    else        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // A request waiting for its ack may not be withdrawn or moved, including the
    // stale one being drained after a redirect.
    hold_req = (state_d == DRAIN) | ((state_q == FETCH) & outstanding & ~branch);
    if (hold_req) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (count_d < FULL);
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_word_q[i] <= '0;
        buf_addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      if (branch) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          buf_word_q[wr_ptr_q] <= imem_rdata;
          buf_addr_q[wr_ptr_q] <= addr_q;
          wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule
